// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_ctrl_if
// Purpose : Shared memory request/ready handshake between the RV32I control
//           FSM (master) and the instruction/data memory port (slave).
// Rev     : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (output mem_req, output mem_we, input mem_ready);
    modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_ctrl
// Purpose : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for an RV32I core.
//           Optional macro MCTRL_PERF_EN adds a retired-instruction counter.
// Rev     : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int ALUOP_W       = 4,
    parameter int FETCH_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               funct7_5,
    input  logic               br_taken,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         pc_sel,
    output logic [1:0]         alu_scr,
    output logic               alu_b_sel,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               rf_we,
    output logic [1:0]         wb_sel,
    output logic [2:0]         state,
`ifdef MCTRL_PERF_EN
    output logic [31:0]        instret,
`endif
    output logic               trap
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;

    localparam logic [ALUOP_W-1:0] c_ALU_ADD    = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] c_ALU_SUB    = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] c_ALU_SLL    = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] c_ALU_SLT    = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] c_ALU_SLTU   = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] c_ALU_XOR    = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] c_ALU_SRL    = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] c_ALU_SRA    = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] c_ALU_OR     = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] c_ALU_AND    = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] c_ALU_PASS_B = ALUOP_W'(10);

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_legal;
    logic                 w_timeout;
    logic                 w_mem_req;
    logic                 w_mem_we;
    logic [1:0]           w_ex_scr;
    logic                 w_ex_b;
    logic [ALUOP_W-1:0]   w_ex_op;
    logic [ALUOP_W-1:0]   w_f3_op;

    always_comb begin
        w_legal = 1'b0;
        case (opcode)
            c_OP_LUI, c_OP_AUIPC, c_OP_JAL, c_OP_JALR, c_OP_BRANCH,
            c_OP_LOAD, c_OP_STORE, c_OP_OPIMM, c_OP_OP: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    // funct7_5 selects SUB only for register-register ops; ADDI ignores it
    always_comb begin
        w_f3_op = c_ALU_ADD;
        case (funct3)
            3'd0:    w_f3_op = ((opcode == c_OP_OP) && funct7_5) ? c_ALU_SUB : c_ALU_ADD;
            3'd1:    w_f3_op = c_ALU_SLL;
            3'd2:    w_f3_op = c_ALU_SLT;
            3'd3:    w_f3_op = c_ALU_SLTU;
            3'd4:    w_f3_op = c_ALU_XOR;
            3'd5:    w_f3_op = funct7_5 ? c_ALU_SRA : c_ALU_SRL;
            3'd6:    w_f3_op = c_ALU_OR;
            default: w_f3_op = c_ALU_AND;
        endcase
    end

    always_comb begin
        w_ex_scr = 2'b00;
        w_ex_b   = 1'b1;
        w_ex_op  = c_ALU_ADD;
        case (opcode)
            c_OP_OP: begin
                w_ex_b  = 1'b0;
                w_ex_op = w_f3_op;
            end
            c_OP_OPIMM:                        w_ex_op  = w_f3_op;
            c_OP_AUIPC, c_OP_JAL, c_OP_BRANCH: w_ex_scr = 2'b10;
            c_OP_LUI: begin
                w_ex_scr = 2'b01;
                w_ex_op  = c_ALU_PASS_B;
            end
            default: ;
        endcase
    end

    generate
        if (FETCH_TIMEOUT > 0) begin : g_timeout
            localparam logic [7:0] c_TO_LAST = 8'(FETCH_TIMEOUT - 1);
            logic [7:0] r_wait_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wait_cnt <= 8'd0;
                end else if (bus.mem_ready || (w_state_next != r_state)) begin
                    r_wait_cnt <= 8'd0;
                end else if (w_mem_req) begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                end
            end

            // Trap on the edge at which the counter would reach the limit
            assign w_timeout = w_mem_req && !bus.mem_ready && (r_wait_cnt == c_TO_LAST);
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_timeout)          w_state_next = S_TRAP;
                else if (bus.mem_ready) w_state_next = S_DECODE;
            end
            S_DECODE: w_state_next = w_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                case (opcode)
                    c_OP_BRANCH:            w_state_next = S_FETCH;
                    c_OP_LOAD, c_OP_STORE:  w_state_next = S_MEM;
                    default:                w_state_next = w_legal ? S_WB : S_TRAP;
                endcase
            end
            S_MEM: begin
                if (w_timeout)          w_state_next = S_TRAP;
                else if (bus.mem_ready) w_state_next = (opcode == c_OP_STORE) ? S_FETCH : S_WB;
            end
            S_WB:    w_state_next = S_FETCH;
            default: w_state_next = S_TRAP;
        endcase
    end

    always_comb begin
        w_mem_req = 1'b0;
        w_mem_we  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'b00;
        alu_scr   = 2'b00;
        alu_b_sel = 1'b0;
        alu_op    = c_ALU_ADD;
        rf_we     = 1'b0;
        wb_sel    = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                ir_we     = bus.mem_ready;
                pc_we     = bus.mem_ready;
            end
            S_EXEC: begin
                alu_scr   = w_ex_scr;
                alu_b_sel = w_ex_b;
                alu_op    = w_ex_op;
                case (opcode)
                    c_OP_BRANCH: begin
                        pc_we  = br_taken;
                        pc_sel = 2'b01;
                    end
                    c_OP_JAL: begin
                        pc_we  = 1'b1;
                        pc_sel = 2'b01;
                    end
                    c_OP_JALR: begin
                        pc_we  = 1'b1;
                        pc_sel = 2'b10;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                w_mem_req = 1'b1;
                w_mem_we  = (opcode == c_OP_STORE);
                alu_scr   = w_ex_scr;
                alu_b_sel = w_ex_b;
                alu_op    = w_ex_op;
            end
            S_WB: begin
                rf_we = 1'b1;
                if (opcode == c_OP_LOAD)                               wb_sel = 2'b01;
                else if ((opcode == c_OP_JAL) || (opcode == c_OP_JALR)) wb_sel = 2'b10;
            end
            default: ;
        endcase
        // While reset is held the state reads FETCH, but nothing may be requested
        if (!rst_n) begin
            w_mem_req = 1'b0;
            w_mem_we  = 1'b0;
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            rf_we     = 1'b0;
        end
    end

    assign bus.mem_req = w_mem_req;
    assign bus.mem_we  = w_mem_we;
    assign state       = 3'(r_state);
    assign trap        = (r_state == S_TRAP);

`ifdef MCTRL_PERF_EN
    logic [31:0] r_instret;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= 32'd0;
        end else if ((w_state_next == S_FETCH) &&
                     ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB))) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign instret = r_instret;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_multicycle_ctrl
// Purpose : Directed self-checking bench for the multi-cycle control FSM.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       br_taken;
    logic       ir_we, pc_we, alu_b_sel, rf_we, trap;
    logic [1:0] pc_sel, alu_scr, wb_sel;
    logic [3:0] alu_op;
    logic [2:0] state;
`ifdef MCTRL_PERF_EN
    logic [31:0] instret;
`endif

    int checks = 0;
    int errors = 0;

    // Per-instruction trace captured by run_instr
    int         n_cyc, rf_cnt, req_cnt, we_cnt;
    logic [1:0] ex_scr, ex_pcsel, wb_s;
    logic       ex_b, ex_pcwe;
    logic [3:0] ex_op;
    logic [2:0] end_state;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.ALUOP_W(4), .FETCH_TIMEOUT(255)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .br_taken  (br_taken),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .alu_scr   (alu_scr),
        .alu_b_sel (alu_b_sel),
        .alu_op    (alu_op),
        .rf_we     (rf_we),
        .wb_sel    (wb_sel),
        .state     (state),
`ifdef MCTRL_PERF_EN
        .instret   (instret),
`endif
        .trap      (trap)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    // Runs one instruction from FETCH until the FSM returns to FETCH or traps
    task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                             input logic bt, input int mem_wait);
        int waited = 0;
        opcode = opc; funct3 = f3; funct7_5 = f75; br_taken = bt;
        n_cyc = 0; rf_cnt = 0; req_cnt = 0; we_cnt = 0;
        ex_scr = 2'bxx; ex_pcsel = 2'bxx; wb_s = 2'bxx; ex_b = 1'bx; ex_pcwe = 1'bx; ex_op = 4'bx;
        do begin
            if (state == 3'd3 && waited < mem_wait) begin
                bus.mem_ready = 1'b0;
                waited++;
            end else begin
                bus.mem_ready = 1'b1;
            end
            #1;
            if (state == 3'd2) begin
                ex_scr = alu_scr; ex_b = alu_b_sel; ex_op = alu_op;
                ex_pcwe = pc_we; ex_pcsel = pc_sel;
            end
            if (state == 3'd4) wb_s = wb_sel;
            if (rf_we) rf_cnt++;
            if (state == 3'd3 && bus.mem_req) begin
                req_cnt++;
                if (bus.mem_we) we_cnt++;
            end
            tick();
            n_cyc++;
        end while (state != 3'd0 && state != 3'd5 && n_cyc < 40);
        end_state = state;
        bus.mem_ready = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; bus.mem_ready = 1'b1;
        opcode = 7'b0110011; funct3 = 3'd0; funct7_5 = 1'b0; br_taken = 1'b0;
        #2;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", bus.mem_req); end
        checks++; if ({ir_we, pc_we, rf_we, bus.mem_we, trap} !== 5'b0) begin errors++; $display("FAIL reset_enables got %b exp 00000", {ir_we, pc_we, rf_we, bus.mem_we, trap}); end
        checks++; if ({alu_scr, alu_b_sel, alu_op, pc_sel, wb_sel} !== 11'b0) begin errors++; $display("FAIL reset_selects got %h exp 0", {alu_scr, alu_b_sel, alu_op, pc_sel, wb_sel}); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.mem_req !== 1'b1 || ir_we !== 1'b1) begin errors++; $display("FAIL first_fetch_req got %b%b exp 11", bus.mem_req, ir_we); end
    endtask

    task automatic test_alu_ops();
        run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, 0);   // ADD
        checks++; if (n_cyc !== 4 || end_state !== 3'd0) begin errors++; $display("FAIL add_latency got %0d/%0d exp 4/0", n_cyc, end_state); end
        checks++; if ({ex_scr, ex_b, ex_op} !== {2'b00, 1'b0, 4'd0}) begin errors++; $display("FAIL add_exec got %b/%b/%0d exp 00/0/0", ex_scr, ex_b, ex_op); end
        checks++; if (rf_cnt !== 1 || wb_s !== 2'b00) begin errors++; $display("FAIL add_wb got rf=%0d wb=%b exp 1/00", rf_cnt, wb_s); end
        run_instr(7'b0110011, 3'd0, 1'b1, 1'b0, 0);   // SUB
        checks++; if (ex_op !== 4'd1) begin errors++; $display("FAIL sub_op got %0d exp 1", ex_op); end
        run_instr(7'b0010011, 3'd5, 1'b1, 1'b0, 0);   // SRAI
        checks++; if ({ex_scr, ex_b, ex_op} !== {2'b00, 1'b1, 4'd7}) begin errors++; $display("FAIL srai_exec got %b/%b/%0d exp 00/1/7", ex_scr, ex_b, ex_op); end
        run_instr(7'b0010011, 3'd0, 1'b1, 1'b0, 0);   // ADDI with IR[30] set
        checks++; if (ex_op !== 4'd0) begin errors++; $display("FAIL addi_op got %0d exp 0", ex_op); end
        run_instr(7'b0110011, 3'd7, 1'b0, 1'b0, 0);   // AND
        checks++; if (ex_op !== 4'd9) begin errors++; $display("FAIL and_op got %0d exp 9", ex_op); end
    endtask

    task automatic test_lui_auipc();
        run_instr(7'b0110111, 3'd0, 1'b0, 1'b0, 0);
        checks++; if ({ex_scr, ex_b, ex_op} !== {2'b01, 1'b1, 4'd10} || n_cyc !== 4) begin errors++; $display("FAIL lui got %b/%b/%0d n=%0d exp 01/1/10 n=4", ex_scr, ex_b, ex_op, n_cyc); end
        run_instr(7'b0010111, 3'd0, 1'b0, 1'b0, 0);
        checks++; if ({ex_scr, ex_b, ex_op} !== {2'b10, 1'b1, 4'd0} || n_cyc !== 4) begin errors++; $display("FAIL auipc got %b/%b/%0d n=%0d exp 10/1/0 n=4", ex_scr, ex_b, ex_op, n_cyc); end
    endtask

    task automatic test_load_store();
        run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 3);   // LW, 3 wait cycles
        checks++; if (req_cnt !== 4 || we_cnt !== 0) begin errors++; $display("FAIL lw_mem got req=%0d we=%0d exp 4/0", req_cnt, we_cnt); end
        checks++; if (wb_s !== 2'b01 || n_cyc !== 8) begin errors++; $display("FAIL lw_wb got wb=%b n=%0d exp 01/8", wb_s, n_cyc); end
        checks++; if ({ex_scr, ex_b, ex_op} !== {2'b00, 1'b1, 4'd0}) begin errors++; $display("FAIL lw_exec got %b/%b/%0d exp 00/1/0", ex_scr, ex_b, ex_op); end
        run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 0);   // SW
        checks++; if (n_cyc !== 4 || we_cnt !== 1 || rf_cnt !== 0) begin errors++; $display("FAIL sw got n=%0d we=%0d rf=%0d exp 4/1/0", n_cyc, we_cnt, rf_cnt); end
    endtask

    task automatic test_branch_jump();
        run_instr(7'b1100011, 3'd0, 1'b0, 1'b1, 0);
        checks++; if (ex_pcwe !== 1'b1 || ex_pcsel !== 2'b01 || ex_scr !== 2'b10 || n_cyc !== 3) begin errors++; $display("FAIL beq_taken got we=%b sel=%b scr=%b n=%0d exp 1/01/10/3", ex_pcwe, ex_pcsel, ex_scr, n_cyc); end
        run_instr(7'b1100011, 3'd0, 1'b0, 1'b0, 0);
        checks++; if (ex_pcwe !== 1'b0 || n_cyc !== 3 || rf_cnt !== 0) begin errors++; $display("FAIL beq_not_taken got we=%b n=%0d rf=%0d exp 0/3/0", ex_pcwe, n_cyc, rf_cnt); end
        run_instr(7'b1100111, 3'd0, 1'b0, 1'b0, 0);
        checks++; if (ex_pcwe !== 1'b1 || ex_pcsel !== 2'b10 || wb_s !== 2'b10 || n_cyc !== 4) begin errors++; $display("FAIL jalr got we=%b sel=%b wb=%b n=%0d exp 1/10/10/4", ex_pcwe, ex_pcsel, wb_s, n_cyc); end
        run_instr(7'b1101111, 3'd0, 1'b0, 1'b0, 0);
        checks++; if (ex_pcsel !== 2'b01 || ex_scr !== 2'b10 || wb_s !== 2'b10) begin errors++; $display("FAIL jal got sel=%b scr=%b wb=%b exp 01/10/10", ex_pcsel, ex_scr, wb_s); end
    endtask

    task automatic test_illegal();
        run_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 0);
        checks++; if (end_state !== 3'd5 || n_cyc !== 2 || trap !== 1'b1) begin errors++; $display("FAIL illegal_trap got st=%0d n=%0d trap=%b exp 5/2/1", end_state, n_cyc, trap); end
        tick(); tick();
        checks++; if (state !== 3'd5 || {bus.mem_req, ir_we, pc_we, rf_we, bus.mem_we} !== 5'b0) begin errors++; $display("FAIL trap_hold got st=%0d en=%b exp 5/00000", state, {bus.mem_req, ir_we, pc_we, rf_we, bus.mem_we}); end
        do_reset();
        checks++; if (state !== 3'd0 || trap !== 1'b0) begin errors++; $display("FAIL trap_clear got st=%0d trap=%b exp 0/0", state, trap); end
    endtask

    task automatic test_timeout();
        bus.mem_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 254; i++) tick();
        checks++; if (state !== 3'd0 || bus.mem_req !== 1'b1) begin errors++; $display("FAIL timeout_early got st=%0d req=%b exp 0/1", state, bus.mem_req); end
        tick();
        checks++; if (state !== 3'd5 || trap !== 1'b1 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL timeout_trap got st=%0d trap=%b req=%b exp 5/1/0", state, trap, bus.mem_req); end
        bus.mem_ready = 1'b1;
        do_reset();
        checks++; if (state !== 3'd0 || trap !== 1'b0) begin errors++; $display("FAIL timeout_clear got st=%0d trap=%b exp 0/0", state, trap); end
    endtask

    task automatic test_reset_mid();
        opcode = 7'b0000011; funct3 = 3'd2; funct7_5 = 1'b0;
        bus.mem_ready = 1'b1;
        tick(); tick();                  // now in EXEC
        bus.mem_ready = 1'b0;
        tick();                          // MEM, waiting
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL mid_setup got st=%0d exp 3", state); end
`ifdef MCTRL_PERF_EN
        checks++; if (instret !== 32'd5) begin errors++; $display("FAIL instret_count got %0d exp 5", instret); end
`endif
        rst_n = 1'b0;
        #1;
        checks++; if (state !== 3'd0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL mid_reset got st=%0d req=%b exp 0/0", state, bus.mem_req); end
`ifdef MCTRL_PERF_EN
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL instret_reset got %0d exp 0", instret); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_instr(7'b0110011, 3'd4, 1'b0, 1'b0, 0);   // XOR
        run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 0);   // SW
        run_instr(7'b1100011, 3'd1, 1'b0, 1'b0, 0);   // BNE not taken
        run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 0);   // LW
        checks++; if (n_cyc !== 5 || wb_s !== 2'b01) begin errors++; $display("FAIL b2b_lw got n=%0d wb=%b exp 5/01", n_cyc, wb_s); end
        run_instr(7'b0110111, 3'd0, 1'b0, 1'b0, 0);   // LUI
        test_reset_mid();
    endtask

    initial begin
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0; br_taken = 1'b0;
        test_reset();
        test_alu_ops();
        test_lui_auipc();
        test_load_store();
        test_branch_jump();
        test_illegal();
        test_timeout();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and write-back for each instruction. It drives the ALU source-select lines (alu_scr: 00 = register-file out1, 01 = extender output, 10 = PC), the second-operand select, the ALU operation, the PC/IR/register-file write enables and the shared memory request/ready handshake.

Parameters:
ALUOP_W, 4, width of alu_op output
FETCH_TIMEOUT, 255, maximum cycles waiting for mem_ready before entering TRAP; 0 = no timeout

Ports:
clk  in  1  core clock, rising-edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7_5  in  1  IR[30]
br_taken  in  1  branch comparator result, valid in EXEC
mem_ready  in  1  memory accepts/completes current request this cycle
mem_req  out  1  memory access request
mem_we  out  1  1 = store
ir_we  out  1  load instruction register
pc_we  out  1  update PC
pc_sel  out  2  00 = PC+4, 01 = ALU result (branch/JAL target), 10 = ALU result & ~1 (JALR)
alu_scr  out  2  ALU A-source select: 00 out1, 01 ext_out, 10 pc
alu_b_sel  out  1  0 = out2, 1 = ext_out
alu_op  out  ALUOP_W  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B
rf_we  out  1  register-file write enable
wb_sel  out  2  00 ALU, 01 load data, 10 PC+4
state  out  3  current state, for debug
trap  out  1  sticky illegal-instruction / timeout flag

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Outputs are a registered-state Moore decode, except mem_req/ir_we/pc_we, which qualify on mem_ready as stated below.
- Reset (async, rst_n=0): state=FETCH, trap=0. All enables and mem_req=0. alu_scr=00, alu_b_sel=0, alu_op=ADD, pc_sel=00, wb_sel=00. After release, the first mem_req occurs in the first FETCH cycle.
- FETCH: mem_req=1, mem_we=0. Hold until mem_ready=1. In that cycle ir_we=1 and pc_we=1 with pc_sel=00; the old PC is kept in the datapath's old-PC register. Next state = DECODE.
- DECODE: one cycle, no enables.
  - Legal opcodes are 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011. Any other opcode -> TRAP.
- EXEC, one cycle. alu_scr/alu_b_sel/alu_op per opcode:
  - OP: 00/0/funct3+funct7_5 decode.
  - OP-IMM: 00/1/funct3 decode. SRAI uses funct7_5; other OP-IMM ignores funct7_5.
  - LOAD/STORE/JALR: 00/1/ADD.
  - AUIPC, JAL, BRANCH target: 10/1/ADD.
  - LUI: 01/1/PASS_B.
  - BRANCH: pc_we=br_taken, pc_sel=01. Next state = FETCH.
  - JAL: pc_sel=01. JALR: pc_sel=10. For both, pc_we=1 and next state = WB.
  - LOAD/STORE -> MEM. All other legal opcodes -> WB.
- MEM: mem_req=1, mem_we=(STORE). Hold alu_scr/alu_b_sel/alu_op as in EXEC. Wait for mem_ready. On mem_ready, STORE -> FETCH and LOAD -> WB.
- WB: rf_we=1 for one cycle. wb_sel: LOAD 01, JAL/JALR 10, others 00. Next state = FETCH.
- TRAP: trap=1 (sticky). All enables 0. The FSM stays in TRAP until reset.
- Timeout: with FETCH_TIMEOUT>0, an 8-bit wait counter increments each cycle mem_req=1 and mem_ready=0. It clears on mem_ready or on a state change. When it reaches FETCH_TIMEOUT, the next state = TRAP.
- mem_req and mem_ready both high in the entry cycle: the transfer completes in that cycle. Minimum latency is then 1 cycle per stage.
- Instruction latency: BRANCH 3, ALU/LUI/AUIPC/JAL/JALR 4, STORE 4, LOAD 5 cycles, plus memory wait cycles.
- rst_n asserted mid-instruction: immediate return to the reset values. The partially executed instruction has no further effect.

Optional Feature:
MCTRL_PERF_EN
- Defined: adds output instret[31:0], reset 0. It increments by 1 in the cycle the FSM leaves EXEC (BRANCH), MEM (STORE) or WB, and wraps at 2^32. It never counts in TRAP.
- Undefined: no instret port and no counter logic.

Test Plan:
- Reset then ADD (opcode 0110011, funct3 0, funct7_5 0), mem_ready tied 1 -> states 0,1,2,4,0. In EXEC: alu_scr=00, alu_b_sel=0, alu_op=0. rf_we=1 for exactly one cycle with wb_sel=00.
- LUI then AUIPC -> EXEC alu_scr=01/alu_op=10 for LUI, then alu_scr=10/alu_op=0 for AUIPC. Each takes 4 cycles.
- LW with mem_ready low for 3 cycles in MEM -> mem_req held 4 cycles with mem_we=0. WB has wb_sel=01. Total 8 cycles.
- BEQ with br_taken=1, then br_taken=0 -> first: pc_we=1 and pc_sel=01 in EXEC. Second: pc_we=0. Each returns to FETCH after 3 cycles.
- Opcode 1111111 -> TRAP after DECODE, trap=1, no enables. Separately, mem_ready held low in FETCH for 255 cycles -> TRAP. rst_n pulse clears trap and returns to FETCH.
- With MCTRL_PERF_EN: run 5 instructions -> instret=5. Reset mid-LOAD -> instret=0.
